// File: rtl/pwm_dac_pkg.sv
// ---------------------------------------------------------------------------
// pwm_dac_pkg
// Shared constants and helpers for the PWM DAC output stage.
//   DEFAULT_WIDTH  : default sample width
//   midscale(w)    : 2^(w-1), the duty used before the first sample arrives
//   period_max(w)  : 2^w - 1, the terminal value of the period counter
// ---------------------------------------------------------------------------
package pwm_dac_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int unsigned midscale(input int unsigned width);
      return 32'd1 << (width - 1);
   endfunction

   function automatic int unsigned period_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// ---------------------------------------------------------------------------
// pwm_dac_if
// Valid/ready sample stream feeding the PWM DAC.
//   din        : unsigned sample from the producer
//   din_valid  : producer has a sample on din
//   din_ready  : consumer can take a sample this cycle
// Modports: master = producer side, slave = pwm_dac side.
// ---------------------------------------------------------------------------
import pwm_dac_pkg::*;

interface pwm_dac_if #(parameter int WIDTH = DEFAULT_WIDTH);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (
      output din,
      output din_valid,
      input  din_ready
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready
   );

endinterface

// File: rtl/pwm_period_counter.sv
// ---------------------------------------------------------------------------
// pwm_period_counter
// Enable-gated wrapping counter that defines the PWM period.
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   en   : count enable; the counter holds while low
//   cnt  : current position within the period
//   tc   : terminal count, high in an enabled cycle with cnt at its maximum,
//          i.e. the cycle whose clock edge ends the period
// ---------------------------------------------------------------------------
import pwm_dac_pkg::*;

module pwm_period_counter #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(period_max(WIDTH));

   // Terminal count is qualified by en so a frozen counter sitting at its
   // maximum does not look like a period boundary.
   assign tc = en && (cnt == CNT_MAX);

   // Natural binary overflow provides the wrap from CNT_MAX back to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_dac.sv
// ---------------------------------------------------------------------------
// pwm_dac
// Converts a stream of unsigned samples into a single-bit PWM output, one
// sample per period of 2^WIDTH clocks. A one-entry holding register lets the
// producer deliver the next sample at any point in the current period; the
// sample becomes the active duty at the following period boundary.
//   clk           : system clock
//   rst           : asynchronous reset, active low
//   en            : run enable; freezes counter, duty and pwm_out when low
//   din_if        : sample stream (slave side)
//   pwm_out       : registered PWM output
//   period_start  : one-cycle pulse in the first cycle of each period
//   underrun      : sticky, set when a boundary finds no fresh sample
// ---------------------------------------------------------------------------
import pwm_dac_pkg::*;

module pwm_dac #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   pwm_dac_if.slave   din_if,
   output logic       pwm_out,
   output logic       period_start,
   output logic       underrun
);

   localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(midscale(WIDTH));

   logic [WIDTH-1:0] cnt;
   logic             boundary;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [WIDTH-1:0] active;
   logic             transfer;

   pwm_period_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .cnt (cnt),
      .tc  (boundary)
   );

   assign din_if.din_ready = !hold_full;
   assign transfer         = din_if.din_valid && !hold_full;

   // Holding register, active duty and underrun flag. A boundary drains the
   // holding register into the active duty; because din_ready is low while
   // the register is full, a drain and a new transfer can never collide. An
   // empty register at the boundary flags underrun, yet a sample arriving in
   // that same cycle is still captured for the next boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
         active    <= MIDSCALE;
         underrun  <= 1'b0;
      end else begin
         if (boundary) begin
            if (hold_full) begin
               active    <= hold;
               hold_full <= 1'b0;
            end else begin
               underrun  <= 1'b1;
            end
         end
         if (transfer) begin
            hold      <= din_if.din;
            hold_full <= 1'b1;
         end
      end
   end

   // PWM comparator and period marker. pwm_out lags cnt by one cycle, so the
   // cycle with cnt == 0 still shows the compare of the previous period's
   // last count, which is always low since active never exceeds the maximum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
         if (en) begin
            pwm_out <= (cnt < active);
         end
      end
   end

endmodule

// File: tb/tb_pwm_dac.sv
// ---------------------------------------------------------------------------
// tb_pwm_dac
// Self-checking bench for pwm_dac with WIDTH = 8 (period 256). Inputs are
// driven and outputs observed on the falling edge; observation c of a
// period is taken after c rising edges of that period, so cnt == c there.
// ---------------------------------------------------------------------------
module tb_pwm_dac;

   localparam int WIDTH  = 8;
   localparam int PERIOD = 256;

   typedef struct {
      bit         push;
      logic [7:0] val;
      int         exp_high;
      bit         exp_underrun;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic pwm_out;
   logic period_start;
   logic underrun;

   int checks = 0;
   int errors = 0;

   pwm_dac_if #(.WIDTH(WIDTH)) din_if ();

   pwm_dac #(
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .din_if       (din_if),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive the producer side of the sample stream.
   task automatic applyStimulus(input logic valid, input logic [7:0] data);
      din_if.din_valid = valid;
      din_if.din       = data;
   endtask

   // Reset without a clock edge, then release on a falling edge with en high.
   task automatic startFromReset();
      applyStimulus(1'b0, 8'd0);
      en = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Observe one full period from the current observation point, counting
   // high pwm_out cycles and period_start pulses.
   task automatic countPeriod(output int high, output int starts);
      high   = 0;
      starts = 0;
      for (int c = 0; c < PERIOD; c++) begin
         high   += int'(pwm_out);
         starts += int'(period_start);
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   high;
      int   starts;
      int   bad;
      logic frozen;

      vecs[0] = '{push: 1'b1, val: 8'd64,  exp_high: 128, exp_underrun: 1'b0};
      vecs[1] = '{push: 1'b1, val: 8'd0,   exp_high: 64,  exp_underrun: 1'b0};
      vecs[2] = '{push: 1'b1, val: 8'd255, exp_high: 0,   exp_underrun: 1'b0};
      vecs[3] = '{push: 1'b0, val: 8'd0,   exp_high: 255, exp_underrun: 1'b0};
      vecs[4] = '{push: 1'b1, val: 8'd100, exp_high: 255, exp_underrun: 1'b1};
      vecs[5] = '{push: 1'b0, val: 8'd0,   exp_high: 100, exp_underrun: 1'b1};

      applyStimulus(1'b0, 8'd0);
      @(negedge clk);
      checkOutput("reset pwm_out", pwm_out, 0);
      checkOutput("reset period_start", period_start, 0);
      checkOutput("reset underrun", underrun, 0);
      checkOutput("reset din_ready", din_if.din_ready, 1);

      // Table-driven periods: push at cnt 10, check duty and flags.
      startFromReset();
      for (int p = 0; p < 6; p++) begin
         high = 0;
         for (int c = 0; c < PERIOD; c++) begin
            if (c == 0) begin
               checkOutput($sformatf("p%0d period_start", p), period_start, (p > 0) ? 1 : 0);
               checkOutput($sformatf("p%0d underrun", p), underrun, vecs[p].exp_underrun);
               checkOutput($sformatf("p%0d din_ready start", p), din_if.din_ready, 1);
            end
            if (c == 1)
               checkOutput($sformatf("p%0d period_start pulse", p), period_start, 0);
            if (c == 11 && vecs[p].push) begin
               checkOutput($sformatf("p%0d din_ready after push", p), din_if.din_ready, 0);
               applyStimulus(1'b0, 8'd0);
            end
            high += int'(pwm_out);
            if (c == 10 && vecs[p].push)
               applyStimulus(1'b1, vecs[p].val);
            @(negedge clk);
         end
         checkOutput($sformatf("p%0d high count", p), high, vecs[p].exp_high);
      end
      checkOutput("underrun sticky", underrun, 1);

      // Reset mid-operation with a sample pending, no clock edge involved.
      applyStimulus(1'b1, 8'd77);
      @(negedge clk);
      applyStimulus(1'b0, 8'd0);
      checkOutput("pending din_ready", din_if.din_ready, 0);
      checkOutput("pre-reset pwm_out", pwm_out, 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("async reset pwm_out", pwm_out, 0);
      checkOutput("async reset underrun", underrun, 0);
      checkOutput("async reset din_ready", din_if.din_ready, 1);
      checkOutput("async reset period_start", period_start, 0);
      @(negedge clk);
      rst = 1'b1;
      countPeriod(high, starts);
      checkOutput("post-reset midscale high", high, 128);
      checkOutput("post-reset no early period_start", starts, 0);
      checkOutput("post-reset first period_start", period_start, 1);
      checkOutput("discarded sample underrun", underrun, 1);
      countPeriod(high, starts);
      checkOutput("discarded sample duty", high, 128);

      // Back-to-back pushes: the second stalls until the boundary.
      startFromReset();
      high = 0;
      bad  = 0;
      for (int c = 0; c < PERIOD; c++) begin
         if (c == 11) begin
            checkOutput("stall first accepted", din_if.din_ready, 0);
            applyStimulus(1'b1, 8'd200);
         end
         if (c > 11 && din_if.din_ready !== 1'b0)
            bad++;
         high += int'(pwm_out);
         if (c == 10)
            applyStimulus(1'b1, 8'd32);
         @(negedge clk);
      end
      checkOutput("stall din_ready held low", bad, 0);
      checkOutput("stall p0 high", high, 128);
      checkOutput("stall boundary din_ready", din_if.din_ready, 1);
      checkOutput("stall boundary underrun", underrun, 0);
      high = int'(pwm_out);
      @(negedge clk);
      checkOutput("stall second accepted", din_if.din_ready, 0);
      applyStimulus(1'b0, 8'd0);
      for (int c = 1; c < PERIOD; c++) begin
         high += int'(pwm_out);
         @(negedge clk);
      end
      checkOutput("stall p1 high", high, 32);
      checkOutput("stall p2 underrun", underrun, 0);
      countPeriod(high, starts);
      checkOutput("stall p2 high", high, 200);

      // Enable dropped for 50 cycles at cnt 100, with a push while frozen.
      startFromReset();
      high = 0;
      for (int c = 0; c < 100; c++) begin
         high += int'(pwm_out);
         @(negedge clk);
      end
      frozen = pwm_out;
      high  += int'(pwm_out);
      en = 1'b0;
      applyStimulus(1'b1, 8'd50);
      bad = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (pwm_out !== frozen || period_start !== 1'b0)
            bad++;
         if (i == 1) begin
            checkOutput("frozen push accepted", din_if.din_ready, 0);
            applyStimulus(1'b0, 8'd0);
         end
      end
      checkOutput("frozen outputs", bad, 0);
      en  = 1'b1;
      bad = 0;
      for (int j = 1; j <= 156; j++) begin
         @(negedge clk);
         if (j < 156) begin
            high += int'(pwm_out);
            if (period_start !== 1'b0)
               bad++;
         end
      end
      checkOutput("resume no early period_start", bad, 0);
      checkOutput("resume period_start after 156", period_start, 1);
      checkOutput("resume period high", high, 128);
      checkOutput("resume underrun", underrun, 0);
      checkOutput("resume din_ready", din_if.din_ready, 1);
      countPeriod(high, starts);
      checkOutput("frozen push duty", high, 50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
Downstream output stage for the sine generator. Consumes WIDTH-bit unsigned samples over a valid/ready handshake and converts each one to a pulse-width-modulated single-bit output, one sample per PWM period of 2^WIDTH clocks. A one-entry holding register decouples the producer from period timing. An underrun flag reports periods that started with no fresh sample.

Parameters:
WIDTH, 8, sample width; PWM period = 2^WIDTH clocks; duty resolution 1/2^WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
en  input  1  PWM run enable; freezes period counter and pwm_out when low
din  input  WIDTH  unsigned sample, 0 = 0% duty
din_valid  input  1  producer has a sample on din
din_ready  output  1  holding register empty; transfer when din_valid && din_ready
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse in the first cycle of each period (cnt == 0 after wrap)
underrun  output  1  sticky; set when a period boundary finds the holding register empty

Behaviour:
- Reset (rst = 0, async): cnt = 0, active = MIDSCALE (2^(WIDTH-1)), hold = 0, hold_full = 0, pwm_out = 0, period_start = 0, underrun = 0. Release is synchronous to clk.
- din_ready = !hold_full (combinational). Transfer cycle: hold <= din, hold_full <= 1. Accepts regardless of en.
- Period counter: when en = 1, cnt increments each clock and wraps from 2^WIDTH-1 to 0. When en = 0, cnt holds.
- Boundary: a cycle with en = 1 and cnt == 2^WIDTH-1.
  - If hold_full = 1: active <= hold, hold_full <= 0.
  - If hold_full = 0: active unchanged, underrun <= 1.
  - din_ready is 0 whenever hold_full = 1, so a load and a transfer never coincide.
  - If hold is empty at the boundary and din_valid = 1, the sample goes into hold. underrun is still set. The sample is used at the next boundary.
- pwm_out:
  - Updates only when en = 1: pwm_out <= (cnt < active), unsigned compare.
  - Lags cnt by one cycle.
  - active = 0 gives constant low; active = 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles. 100% duty is not reachable.
- period_start <= (en && cnt == 2^WIDTH-1). It is high in the cycle where cnt == 0 after a wrap. It is 0 after reset until the first wrap.
- Latency: a sample accepted in period N drives duty in period N+1. pwm_out reflects the new value from the second cycle of that period.
- en low mid-period: cnt, active, pwm_out and period_start freeze; period_start is forced to 0. The handshake keeps operating. Resuming continues from the frozen cnt.
- underrun clears only on reset.
- Reset mid-operation: all state returns to reset values immediately, including a pending sample in hold, which is discarded.

Decomposition:
- Package pwm_dac_pkg: function/localparam for MIDSCALE(WIDTH) and PERIOD_MAX(WIDTH) = 2^WIDTH-1.
- Sub-module pwm_period_counter (WIDTH): en-gated wrapping counter with terminal-count output. It is reused by the top for boundary detection and period_start.
- Holding register, active register and compare stay in pwm_dac.

Test Plan (WIDTH = 8, period 256):
1. Assert rst = 0 mid-clock -> outputs go to reset values immediately with no clk edge. After release: din_ready = 1, active = 128, pwm_out high 128 of 256 cycles per period, period_start first pulses 256 cycles after release.
2. en = 1, push din = 64 at cycle 10 -> din_ready drops the next cycle. At the first boundary hold loads and din_ready returns to 1. The next period has pwm_out high exactly 64 consecutive cycles. underrun = 0.
3. Push 0, then 255, in successive periods -> one period fully low, then high 255 cycles and low 1 cycle.
4. Push nothing across a boundary -> underrun = 1 from the cycle after the boundary and stays 1. Duty repeats the previous value. A later push and reset behave normally; underrun clears only on rst.
5. Push 32 and then 200 within one period with din_valid held high -> 200 stalls with din_ready = 0 until the boundary. It is accepted the cycle after. Duty sequence is 32 then 200, with no sample lost.
6. Drop en for 50 cycles at cnt = 100 -> cnt and pwm_out frozen and no period_start. The period completes 156 enabled cycles after resume. A push during en = 0 is accepted.
